// File: rtl/mtr_drv.sv
// Motor drive stage: converts signed left/right speed commands into
// complementary PWM pairs with dead-time, one pair per H-bridge.
// Both channels share one free-running 2048-clock period counter, and the
// speed commands are captured into shadow duties only at the period wrap.

// One H-bridge channel: raw comparator PWM followed by dead-time insertion.
module mtr_drv_chan #(
  parameter int unsigned DEAD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] cnt,
  input  logic [10:0] duty,
  output logic        pwm1,
  output logic        pwm2
);

  logic       r;
  logic       r_prev;
  logic [7:0] deadcnt;

  // Raw PWM is high while the period counter is below the shadow duty.
  assign r = (cnt < duty);

  // Any raw edge (re)starts the dead interval with both sides off; once the
  // raw level has been stable for DEAD clocks the matching side is driven.
  // A raw pulse shorter than the dead interval is swallowed because its
  // second edge simply reloads the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      deadcnt <= 8'd0;
      pwm1    <= 1'b0;
      pwm2    <= 1'b0;
    end else begin
      r_prev <= r;
      if (r != r_prev) begin
        deadcnt <= 8'(DEAD);
        pwm1    <= 1'b0;
        pwm2    <= 1'b0;
      end else if (deadcnt != 8'd0) begin
        deadcnt <= deadcnt - 8'd1;
        pwm1    <= 1'b0;
        pwm2    <= 1'b0;
      end else begin
        pwm1 <= r;
        pwm2 <= ~r;
      end
    end
  end

endmodule

// Top level: shared period counter, double-buffered duties, two channels.
module mtr_drv #(
  parameter int unsigned DEAD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        prd_strt
);

  localparam logic [10:0] CNT_LAST  = 11'd2047;
  localparam logic [10:0] DUTY_ZERO = 11'd1024;

  logic [10:0] cnt;
  logic [10:0] duty_l;
  logic [10:0] duty_r;
  logic        cnt_wrap;

  assign cnt_wrap = (cnt == CNT_LAST);
  assign prd_strt = (cnt == 11'd0);

  // Free-running period counter; wraps naturally from 2047 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 11'd0;
    end else begin
      cnt <= cnt + 11'd1;
    end
  end

  // Shadow duties: flipping the sign bit turns the two's-complement speed
  // into offset binary (-1024 -> 0, 0 -> 1024, +1023 -> 2047). Loading only
  // on the wrap edge keeps every period's duty glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_l <= DUTY_ZERO;
      duty_r <= DUTY_ZERO;
    end else if (cnt_wrap) begin
      duty_l <= {~lft_spd[10], lft_spd[9:0]};
      duty_r <= {~rght_spd[10], rght_spd[9:0]};
    end
  end

  mtr_drv_chan #(.DEAD(DEAD)) u_lft (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .duty (duty_l),
    .pwm1 (lftPWM1),
    .pwm2 (lftPWM2)
  );

  mtr_drv_chan #(.DEAD(DEAD)) u_rght (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .duty (duty_r),
    .pwm1 (rghtPWM1),
    .pwm2 (rghtPWM2)
  );

endmodule
